// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: DEPTH-deep valid/ctrl/data inter-stage register; PIPE_REG_STATS_EN adds stall/flush counters.
// Latency: DEPTH edges from the capture edge, outputs come straight from the last stage register.
// Backpressure: Stall holds the whole chain; Flush clears every stage and wins over Stall.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int DEPTH  = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              InValid,
    input  logic [CTRL_W-1:0] InCtrl,
    input  logic [DATA_W-1:0] InData,
    output logic              OutValid,
    output logic [CTRL_W-1:0] OutCtrl,
    output logic [DATA_W-1:0] OutData
`ifdef PIPE_REG_STATS_EN
    ,
    output logic [15:0]       StallCnt,
    output logic [15:0]       FlushCnt
`endif
);

    typedef struct packed {
        logic              vld;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] dat;
    } stage_t;

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("pipe_stage_reg: DEPTH must be in 1..4");
        end
    endgenerate

    stage_t stg_q [DEPTH];
    stage_t in_stage;

    // Bubbles carry zero control so they can never fire RegWrite/MemWrite/Branch.
    always_comb begin
        in_stage      = '0;
        in_stage.vld  = InValid;
        in_stage.ctrl = InValid ? InCtrl : '0;
        in_stage.dat  = InData;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg_q[i] <= '0;
            end
        end else if (Flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg_q[i] <= '0;
            end
        end else if (!Stall) begin
            stg_q[0] <= in_stage;
            for (int i = 1; i < DEPTH; i++) begin
                stg_q[i] <= stg_q[i-1];
            end
        end
    end

    assign OutValid = stg_q[DEPTH-1].vld;
    assign OutCtrl  = stg_q[DEPTH-1].ctrl;
    assign OutData  = stg_q[DEPTH-1].dat;

`ifdef PIPE_REG_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Saturating counters; a flushed cycle is never counted as a stall.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (Stall && !Flush && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (Flush && flush_cnt_q != 16'hFFFF) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboarded bench for pipe_stage_reg: DEPTH=2 and DEPTH=3 instances share stimulus,
// each with its own expected-word queue checked by a negedge monitor.
module tb_pipe_stage_reg;

    logic        Clk;
    logic        Rst;
    logic        Stall;
    logic        Flush;
    logic        InValid;
    logic [15:0] InCtrl;
    logic [31:0] InData;

    logic        v2, v3;
    logic [15:0] c2, c3;
    logic [31:0] d2, d3;
`ifdef PIPE_REG_STATS_EN
    logic [15:0] sc2, fc2, sc3, fc3;
`endif

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .DEPTH(2)) u_d2 (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
        .InValid(InValid), .InCtrl(InCtrl), .InData(InData),
        .OutValid(v2), .OutCtrl(c2), .OutData(d2)
`ifdef PIPE_REG_STATS_EN
        , .StallCnt(sc2), .FlushCnt(fc2)
`endif
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .DEPTH(3)) u_d3 (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
        .InValid(InValid), .InCtrl(InCtrl), .InData(InData),
        .OutValid(v3), .OutCtrl(c3), .OutData(d3)
`ifdef PIPE_REG_STATS_EN
        , .StallCnt(sc3), .FlushCnt(fc3)
`endif
    );

    typedef struct {
        logic [15:0] ctrl;
        logic [31:0] dat;
        int          cap;
    } exp_t;

    exp_t q2[$];
    exp_t q3[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int shift_cnt = 0;
    logic shift_e = 1'b0;
    logic stall_e = 1'b0;
    logic flush_e = 1'b0;

    logic        pv2 = 1'b0, pv3 = 1'b0;
    logic [15:0] pc2 = '0, pc3 = '0;
    logic [31:0] pd2 = '0, pd3 = '0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Classify the edge just taken so the monitor knows what the outputs should have done.
    always @(posedge Clk) begin
        shift_e = Rst && !Stall && !Flush;
        stall_e = Rst && Stall && !Flush;
        flush_e = Rst && Flush;
        if (shift_e) shift_cnt++;
    end

    task automatic mon(input int id, input int depth, input logic v, input logic [15:0] c,
                       input logic [31:0] d, input logic pv, input logic [15:0] pc,
                       input logic [31:0] pd);
        exp_t e;
        if (!Rst) begin
            check($sformatf("d%0d_rst_valid", depth), 64'(v), 64'(0));
            check($sformatf("d%0d_rst_ctrl", depth), 64'(c), 64'(0));
            check($sformatf("d%0d_rst_data", depth), 64'(d), 64'(0));
        end else if (flush_e) begin
            check($sformatf("d%0d_flush_valid", depth), 64'(v), 64'(0));
            check($sformatf("d%0d_flush_ctrl", depth), 64'(c), 64'(0));
        end else if (stall_e) begin
            check($sformatf("d%0d_stall_hold", depth), {15'd0, v, c, d}, {15'd0, pv, pc, pd});
        end else if (shift_e) begin
            if (v) begin
                if ((id == 0 && q2.size() == 0) || (id == 1 && q3.size() == 0)) begin
                    check($sformatf("d%0d_unexpected_word", depth), 64'(d), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = (id == 0) ? q2.pop_front() : q3.pop_front();
                    check($sformatf("d%0d_ctrl", depth), 64'(c), 64'(e.ctrl));
                    check($sformatf("d%0d_data", depth), 64'(d), 64'(e.dat));
                    check($sformatf("d%0d_latency", depth), 64'(shift_cnt - e.cap), 64'(depth - 1));
                end
            end else begin
                check($sformatf("d%0d_bubble_ctrl", depth), 64'(c), 64'(0));
            end
        end
    endtask

    always @(negedge Clk) begin
        mon(0, 2, v2, c2, d2, pv2, pc2, pd2);
        mon(1, 3, v3, c3, d3, pv3, pc3, pd3);
        pv2 = v2; pc2 = c2; pd2 = d2;
        pv3 = v3; pc3 = c3; pd3 = d3;
    end

    // Called at posedge+2; presents one input word for the next edge.
    task automatic drive(input logic v, input logic [15:0] c, input logic [31:0] d,
                         input logic st, input logic fl, input logic expect_out);
        exp_t e;
        InValid = v;
        InCtrl  = c;
        InData  = d;
        Stall   = st;
        Flush   = fl;
        if (expect_out) begin
            e.ctrl = c;
            e.dat  = d;
            e.cap  = shift_cnt + 1;
            q2.push_back(e);
            q3.push_back(e);
        end
        @(posedge Clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'hFFFF, 32'hBBBB_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        Rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
        InValid = 1'b1; InCtrl = 16'h01FF; InData = 32'h0000_003F;
        #1 Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        Rst = 1'b1;

        // Word held during reset is captured on the first edge after release.
        drive(1'b1, 16'h01FF, 32'h0000_003F, 1'b0, 1'b0, 1'b1);
        idle(4);

        for (int i = 1; i <= 4; i++) drive(1'b1, 16'h0100 | 16'(i), 32'(i), 1'b0, 1'b0, 1'b1);
        idle(4);

        drive(1'b1, 16'h0A01, 32'd127, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'h0A02, 32'd255, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'h0BAD, 32'hDEAD, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 16'h0BAD, 32'hBEEF, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 16'h0A03, 32'd511, 1'b0, 1'b0, 1'b1);
        idle(4);
`ifdef PIPE_REG_STATS_EN
        check("stall_cnt_after_stall", 64'(sc2), 64'd2);
        check("flush_cnt_after_stall", 64'(fc2), 64'd0);
`endif

        // 255 sits in stage 0 when the flush edge arrives and must never emerge.
        drive(1'b1, 16'h0C01, 32'd255, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h0C02, 32'h77, 1'b0, 1'b1, 1'b0);
        idle(3);
`ifdef PIPE_REG_STATS_EN
        check("flush_cnt_after_flush", 64'(fc2), 64'd1);
`endif
        drive(1'b1, 16'h0D01, 32'h1234, 1'b0, 1'b0, 1'b1);
        idle(4);

        drive(1'b1, 16'h0E01, 32'h55, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h0E02, 32'h66, 1'b1, 1'b1, 1'b0);
        idle(3);
`ifdef PIPE_REG_STATS_EN
        check("flush_cnt_flush_stall", 64'(fc2), 64'd2);
        check("stall_cnt_flush_stall", 64'(sc2), 64'd2);
`endif
        drive(1'b1, 16'h0F01, 32'hCAFE, 1'b0, 1'b0, 1'b1);
        idle(4);

`ifdef PIPE_REG_STATS_EN
        Stall = 1'b1;
        repeat (65540) @(posedge Clk);
        #2;
        check("stall_cnt_saturated", 64'(sc2), 64'hFFFF);
        @(posedge Clk);
        #2;
        check("stall_cnt_stays_sat", 64'(sc3), 64'hFFFF);
        Rst = 1'b0;
        #1;
        check("stall_cnt_reset", 64'(sc2), 64'd0);
        check("flush_cnt_reset", 64'(fc2), 64'd0);
        @(posedge Clk);
        #2;
        Stall = 1'b0;
        Rst = 1'b1;
        idle(2);
`endif

        check("d2_queue_drained", 64'(q2.size()), 64'd0);
        check("d3_queue_drained", 64'(q3.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

- Parametrised successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined MIPS datapath.
- Carries a packed control bundle and a packed data bundle through DEPTH register stages, each with a valid bit.
- Supports pipeline stall (hold) and flush (bubble insertion) driven by the hazard unit.
- Serves as the single reusable stage register for every boundary of the pipeline.

## Interface

Parameters:
- DATA_W, 32, width of the packed data bundle (PC+4, RD1, RD2, sign-extended immediate, register fields, etc.)
- CTRL_W, 16, width of the packed control bundle (RegDst, Branch, MemRead, ALUOp, jump controls, etc.)
- DEPTH, 1, number of register stages in series; legal range 1..4

Ports:
- Clk  in  1  system clock; all state updates on the rising edge
- Rst  in  1  asynchronous, active-low reset
- Stall  in  1  hold all stages; the input is not captured
- Flush  in  1  invalidate all stages and the incoming word on this edge
- InValid  in  1  the incoming word is a real instruction
- InCtrl  in  CTRL_W  control bundle from the upstream stage
- InData  in  DATA_W  data bundle from the upstream stage
- OutValid  out  1  valid bit of the last stage
- OutCtrl  out  CTRL_W  control bundle of the last stage
- OutData  out  DATA_W  data bundle of the last stage
- StallCnt  out  16  saturating stall-cycle count; present only with PIPE_REG_STATS_EN
- FlushCnt  out  16  saturating flush-cycle count; present only with PIPE_REG_STATS_EN

## Operation

Each stage k (0..DEPTH-1) holds valid[k], ctrl[k] and data[k]. Stage 0 is fed by the inputs; stage k is fed by stage k-1. The outputs are stage DEPTH-1 directly, with no combinational path from input to output.

Per rising edge, in priority order:
- **Flush=1:** every stage loads valid=0, ctrl=0, data=0. This overrides Stall.
- **Stall=1 (Flush=0):** every stage holds its value. In* is ignored.
- **Otherwise:** the pipeline shifts.
  - Stage 0 loads valid=InValid.
  - Stage 0 loads ctrl=(InValid ? InCtrl : 0).
  - Stage 0 loads data=InData.
  - Stage k loads stage k-1.

Additional rules:
- **Bubble invariant:** whenever valid[k]=0, ctrl[k]=0. This guarantees that a bubble never asserts RegWrite, MemWrite or Branch downstream.
- **Data in bubbles:** data passes unmodified through a bubble; it is don't-care for consumers.
- **Stall scope:** Stall applies to the whole register chain. Partial-stage stall is not supported.
- **DEPTH outside 1..4:** elaboration error, raised via a generate-time $error.

## Timing

- **Reset:** Rst=0 asynchronously forces OutValid=0, OutCtrl=0, OutData=0, all internal stages to 0, and StallCnt=FlushCnt=0. Deassertion is taken synchronously on the next edge by the system reset synchroniser; this block has no internal synchroniser.
- **Latency:** a word captured at edge n appears on Out* after edge n+DEPTH-1, i.e. DEPTH edges from the capture edge counting it, assuming no stall.
- **Stalls:** each Stall cycle adds exactly one cycle of latency to every in-flight word. No word is lost or duplicated.
- **Flush:** takes effect on the same edge as it is sampled. OutValid=0 is visible immediately after that edge.
- **Flush+Stall in the same cycle:** the flush result applies.
- **Reset mid-operation:** all in-flight words are discarded. There is no replay.

## Configuration

Macro: PIPE_REG_STATS_EN

- **Defined:**
  - StallCnt and FlushCnt ports exist.
  - StallCnt increments on each edge with Stall=1 and Flush=0.
  - FlushCnt increments on each edge with Flush=1.
  - Both saturate at 16'hFFFF and clear only on reset.
- **Undefined:** the ports and counters are absent, with zero area cost. Stage behaviour is identical in both cases.

## Test plan

- **Reset:** DEPTH=2. Hold Rst=0 with InValid=1, InCtrl=16'h01FF, InData=32'h0000_003F → outputs stay all-zero. Release Rst → after 2 edges OutValid=1, OutCtrl=16'h01FF, OutData=32'h0000_003F.
- **Streaming:** DEPTH=3. Drive InData = 1, 2, 3, 4 on consecutive edges with InValid=1 → OutData = 1, 2, 3, 4 starting 3 edges after the first capture, with no gaps.
- **Stall:** DEPTH=2. Assert Stall for 2 cycles mid-stream of words 127, 255, 511 → outputs hold the current word for 2 extra cycles. Sequence is 127, 255, 511 with no loss or duplication; StallCnt=2.
- **Flush and bubble:** DEPTH=2. Assert Flush one cycle while word 255 is in stage 0 → for the next 2 edges OutValid=0 and OutCtrl=0; FlushCnt=1. Separately, drive InValid=0 with InCtrl=16'hFFFF → the bubble emerges with OutCtrl=0.
- **Flush+Stall together:** Flush=1, Stall=1 → all stages cleared, OutValid=0; FlushCnt increments, StallCnt does not.
- **Saturation:** with PIPE_REG_STATS_EN, hold Stall=1 for 65,540 cycles → StallCnt=16'hFFFF and stays there. Rst=0 → StallCnt=0.
